switch_debounce: RTL

//  Conditions raw slide-switch / push-button levels before they drive the combinational gate stage.
//  Per channel it provides:
//   - a multi-flop synchronizer into clk;
//   - a stable-period debounce filter;
//   - optional one-cycle edge pulses.
//  sw_clean[0] feeds gate input a and sw_clean[1] feeds gate input b.
//  The block sits between the board I/O pins and the gate logic.

---
 rtl/switch_debounce.sv | 133 +++++++++++++
 1 files changed

// File: rtl/switch_debounce.sv
// ---------------------------------------------------------------------------
// switch_debounce
//
// Conditions raw slide-switch / push-button levels before they reach the
// combinational gate stage. Each channel is handled on its own:
//   1. a SYNC_STAGES-deep flop chain brings the asynchronous pin level into
//      the clk domain;
//   2. a stable-period filter only accepts a new level after the
//      synchronized input has disagreed with the current clean level for
//      DEBOUNCE_CYCLES consecutive clock edges;
//   3. optional registered one-cycle rise/fall strobes follow sw_clean.
// sw_clean[0] drives gate input a, sw_clean[1] drives gate input b.
//
// Configuration macro: SWITCH_DEBOUNCE_EDGE_EN
//   defined   -> rise_pulse / fall_pulse strobes are generated
//   undefined -> no pulse logic is built, both pulse ports are tied to 0
//   sw_clean behaves identically in both builds.
//
// Ports
//   clk         in   1      system clock, rising edge
//   rst         in   1      asynchronous, active-high reset
//   sw_in       in   WIDTH  raw switch levels, asynchronous to clk
//   sw_clean    out  WIDTH  debounced, synchronized levels (registered)
//   rise_pulse  out  WIDTH  1-cycle strobe on sw_clean 0->1 (registered)
//   fall_pulse  out  WIDTH  1-cycle strobe on sw_clean 1->0 (registered)
// ---------------------------------------------------------------------------
module switch_debounce #(
  parameter int WIDTH           = 2,
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int CNT_W           = 20
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] sw_in,
  output logic [WIDTH-1:0] sw_clean,
  output logic [WIDTH-1:0] rise_pulse,
  output logic [WIDTH-1:0] fall_pulse
);

  // Terminal count: the level is accepted on the edge where the counter
  // would otherwise step past this value.
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  // Per-channel next-state of the clean level, shared with the pulse logic
  // so the strobes line up with the edge on which sw_clean changes.
  logic [WIDTH-1:0] cleanD;
  logic [WIDTH-1:0] cleanQ;

  genvar gi;
  generate
    for (gi = 0; gi < WIDTH; gi++) begin : gChan

      logic [SYNC_STAGES-1:0] syncQ;
      logic                   syncS;
      logic [CNT_W-1:0]       cntQ;
      logic [CNT_W-1:0]       cntD;

      // Synchronizer chain: bit 0 samples the pin, the top bit is the
      // value the filter is allowed to look at.
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          syncQ <= '0;
        end else begin
          syncQ <= {syncQ[SYNC_STAGES-2:0], sw_in[gi]};
        end
      end

      assign syncS = syncQ[SYNC_STAGES-1];

      // Filter: any agreement clears the count (no partial credit across
      // bounces); a full run of disagreement commits the sampled level.
      // The >= guard keeps the counter from ever wrapping.
      always_comb begin
        cntD       = cntQ;
        cleanD[gi] = cleanQ[gi];
        if (syncS == cleanQ[gi]) begin
          cntD = '0;
        end else if (cntQ >= CNT_MAX) begin
          cleanD[gi] = syncS;
          cntD       = '0;
        end else begin
          cntD = cntQ + CNT_W'(1);
        end
      end

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          cntQ       <= '0;
          cleanQ[gi] <= 1'b0;
        end else begin
          cntQ       <= cntD;
          cleanQ[gi] <= cleanD[gi];
        end
      end

    end
  endgenerate

  assign sw_clean = cleanQ;

`ifdef SWITCH_DEBOUNCE_EDGE_EN
  logic [WIDTH-1:0] riseQ;
  logic [WIDTH-1:0] fallQ;
  logic [WIDTH-1:0] riseD;
  logic [WIDTH-1:0] fallD;

  // Strobes are decoded from the pending clean-level change so they are
  // registered on the same edge as sw_clean and drop on the next edge,
  // since the filter cannot commit twice in a row.
  always_comb begin
    riseD = cleanD & ~cleanQ;
    fallD = ~cleanD & cleanQ;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      riseQ <= '0;
      fallQ <= '0;
    end else begin
      riseQ <= riseD;
      fallQ <= fallD;
    end
  end

  assign rise_pulse = riseQ;
  assign fall_pulse = fallQ;
`else
  assign rise_pulse = '0;
  assign fall_pulse = '0;
`endif

endmodule
